// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time,
// buffers the returned word in a 1-entry skid buffer and loads the IF/ID register.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            HD_HoldPC,
    input  logic            HD_Hold_IF_ID,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            IF_ID_Valid,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic [XLEN-1:0] IF_ID_Instr
);

    typedef enum logic {S_REQ, S_WAIT} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_drop;
    logic            r_ibuf_valid;
    logic [XLEN-1:0] r_ibuf_pc;
    logic [XLEN-1:0] r_ibuf_instr;

    logic            w_drain;
    logic            w_capture;

    assign w_drain   = r_ibuf_valid & ~HD_Hold_IF_ID & ~branch_taken;
    assign w_capture = (r_state == S_WAIT) & imem_rvalid & ~r_drop & ~branch_taken;

    // Request is gated by rst_n so the bus stays quiet while reset is held.
    assign imem_req  = rst_n & (r_state == S_REQ) & ~HD_HoldPC & ~branch_taken
                     & (~r_ibuf_valid | w_drain);
    assign imem_addr = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_ibuf_valid <= 1'b0;
            r_ibuf_pc    <= '0;
            r_ibuf_instr <= NOP_INSTR;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_req && imem_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Any response ends the transaction; only one can be outstanding.
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                        r_drop  <= 1'b0;
                    end else if (branch_taken) begin
                        r_drop  <= 1'b1;
                    end
                end
                default: r_state <= S_REQ;
            endcase

            if (branch_taken) begin
                r_pc <= branch_target;
            end else if (w_capture) begin
                r_pc <= r_pc + XLEN'(4);
            end

            if (branch_taken) begin
                r_ibuf_valid <= 1'b0;
            end else if (w_capture) begin
                r_ibuf_valid <= 1'b1;
                r_ibuf_pc    <= r_pc;
                r_ibuf_instr <= imem_rdata;
            end else if (w_drain) begin
                r_ibuf_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IF_ID_Valid <= 1'b0;
            IF_ID_PC    <= '0;
            IF_ID_Instr <= NOP_INSTR;
        end else if (branch_taken) begin
            IF_ID_Valid <= 1'b0;
            IF_ID_Instr <= NOP_INSTR;
        end else if (HD_Hold_IF_ID) begin
            IF_ID_Valid <= IF_ID_Valid;
        end else if (w_drain) begin
            IF_ID_Valid <= 1'b1;
            IF_ID_PC    <= r_ibuf_pc;
            IF_ID_Instr <= r_ibuf_instr;
        end else begin
            IF_ID_Valid <= 1'b0;
            IF_ID_Instr <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a tick-driven memory responder plus scenario tasks
// with hand-computed expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        HD_HoldPC = 1'b0;
    logic        HD_Hold_IF_ID = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        IF_ID_Valid;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Instr;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          mem_auto = 1'b0;
    logic        mem_hs;
    logic [31:0] mem_addr;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst_n(rst_n), .HD_HoldPC(HD_HoldPC), .HD_Hold_IF_ID(HD_Hold_IF_ID),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_ID_Valid(IF_ID_Valid), .IF_ID_PC(IF_ID_PC), .IF_ID_Instr(IF_ID_Instr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: sample the handshake mid-cycle, then answer it one cycle later.
    task automatic tick();
        @(negedge clk);
        mem_hs   = imem_req & imem_ready;
        mem_addr = imem_addr;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            imem_rvalid = mem_hs;
            imem_rdata  = mem_hs ? (mem_addr ^ KEY) : '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; HD_HoldPC = 1'b0; HD_Hold_IF_ID = 1'b0; branch_taken = 1'b0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; mem_auto = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", IF_ID_Valid); end
        n_cmp++; if (IF_ID_PC !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 00000000", IF_ID_PC); end
        n_cmp++; if (IF_ID_Instr !== NOP) begin n_bad++; $display("FAIL rst_instr: got %h want %h", IF_ID_Instr, NOP); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rel_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rel_addr: got %h want 00000000", imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        mem_auto = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            exp_pc = 32'(k * 4);
            tick();
            n_cmp++; if (IF_ID_Valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want 1", k, IF_ID_Valid); end
            n_cmp++; if (IF_ID_PC !== exp_pc) begin n_bad++; $display("FAIL stream_pc[%0d]: got %h want %h", k, IF_ID_PC, exp_pc); end
            n_cmp++; if (IF_ID_Instr !== (exp_pc ^ KEY)) begin n_bad++; $display("FAIL stream_instr[%0d]: got %h want %h", k, IF_ID_Instr, exp_pc ^ KEY); end
            tick();
            n_cmp++; if (IF_ID_Valid !== 1'b0) begin n_bad++; $display("FAIL stream_bubble[%0d]: got %b want 0", k, IF_ID_Valid); end
            n_cmp++; if (IF_ID_Instr !== NOP) begin n_bad++; $display("FAIL stream_nop[%0d]: got %h want %h", k, IF_ID_Instr, NOP); end
        end
        tick();
        n_cmp++; if (IF_ID_PC !== 32'hC || IF_ID_Valid !== 1'b1) begin n_bad++; $display("FAIL stream_pc3: got %h/%b want 0000000c/1", IF_ID_PC, IF_ID_Valid); end
    endtask

    task automatic test_hold();
        HD_HoldPC = 1'b1; HD_Hold_IF_ID = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL hold_req0: got %b want 0", imem_req); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL hold_req[%0d]: got %b want 0", i, imem_req); end
            n_cmp++; if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'hC || IF_ID_Instr !== 32'hA5A5_000C) begin
                n_bad++; $display("FAIL hold_ifid[%0d]: got %b/%h/%h want 1/0000000c/a5a5000c", i, IF_ID_Valid, IF_ID_PC, IF_ID_Instr);
            end
        end
        HD_HoldPC = 1'b0; HD_Hold_IF_ID = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin n_bad++; $display("FAIL hold_resume_req: got %b/%h want 1/00000014", imem_req, imem_addr); end
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'h10 || IF_ID_Instr !== 32'hA5A5_0010) begin
            n_bad++; $display("FAIL hold_release: got %b/%h/%h want 1/00000010/a5a50010", IF_ID_Valid, IF_ID_PC, IF_ID_Instr);
        end
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b0) begin n_bad++; $display("FAIL hold_bubble: got %b want 0", IF_ID_Valid); end
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'h14) begin n_bad++; $display("FAIL hold_next: got %b/%h want 1/00000014", IF_ID_Valid, IF_ID_PC); end
    endtask

    task automatic test_branch_wait();
        do_reset();
        tick();
        branch_taken = 1'b1; branch_target = 32'h100;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL br_wait_req: got %b want 0", imem_req); end
        tick();
        branch_taken = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_DEAD;
        tick();
        imem_rvalid = 1'b0; imem_rdata = '0;
        #1;
        n_cmp++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== NOP) begin n_bad++; $display("FAIL br_drop_ifid: got %b/%h want 0/%h", IF_ID_Valid, IF_ID_Instr, NOP); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_bad++; $display("FAIL br_new_addr: got %b/%h want 1/00000100", imem_req, imem_addr); end
        mem_auto = 1'b1;
        tick();
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b0) begin n_bad++; $display("FAIL br_dead_leak: got %b/%h want 0", IF_ID_Valid, IF_ID_Instr); end
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'h100 || IF_ID_Instr !== 32'hA5A5_0100) begin
            n_bad++; $display("FAIL br_target_ifid: got %b/%h/%h want 1/00000100/a5a50100", IF_ID_Valid, IF_ID_PC, IF_ID_Instr);
        end
    endtask

    task automatic test_branch_hold();
        HD_HoldPC = 1'b1; HD_Hold_IF_ID = 1'b1;
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'h100) begin n_bad++; $display("FAIL brh_pre: got %b/%h want 1/00000100", IF_ID_Valid, IF_ID_PC); end
        branch_taken = 1'b1; branch_target = 32'h200;
        tick();
        branch_taken = 1'b0; HD_HoldPC = 1'b0; HD_Hold_IF_ID = 1'b0;
        n_cmp++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'h0000_0013) begin
            n_bad++; $display("FAIL brh_flush: got %b/%h want 0/00000013", IF_ID_Valid, IF_ID_Instr);
        end
        #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_bad++; $display("FAIL brh_addr: got %b/%h want 1/00000200", imem_req, imem_addr); end
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b0) begin n_bad++; $display("FAIL brh_ibuf_empty: got %b/%h want 0", IF_ID_Valid, IF_ID_PC); end
        tick();
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'h200) begin n_bad++; $display("FAIL brh_target: got %b/%h want 1/00000200", IF_ID_Valid, IF_ID_PC); end
    endtask

    task automatic test_ready_low();
        imem_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'h204) begin n_bad++; $display("FAIL rdy_pre: got %b/%h want 1/00000204", IF_ID_Valid, IF_ID_PC); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h208) begin n_bad++; $display("FAIL rdy_req[%0d]: got %b/%h want 1/00000208", i, imem_req, imem_addr); end
            tick();
            n_cmp++; if (IF_ID_Valid !== 1'b0) begin n_bad++; $display("FAIL rdy_bubble[%0d]: got %b want 0", i, IF_ID_Valid); end
        end
        imem_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b0) begin n_bad++; $display("FAIL rdy_wait: got %b want 0", IF_ID_Valid); end
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'h208 || IF_ID_Instr !== 32'hA5A5_0208) begin
            n_bad++; $display("FAIL rdy_data: got %b/%h/%h want 1/00000208/a5a50208", IF_ID_Valid, IF_ID_PC, IF_ID_Instr);
        end
    endtask

    task automatic test_reset_mid();
        mem_auto = 1'b0; imem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (IF_ID_Valid !== 1'b0 || IF_ID_PC !== 32'h0 || IF_ID_Instr !== NOP) begin
            n_bad++; $display("FAIL rmid_ifid: got %b/%h/%h want 0/00000000/%h", IF_ID_Valid, IF_ID_PC, IF_ID_Instr, NOP);
        end
        n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL rmid_req: got %b/%h want 0/00000000", imem_req, imem_addr); end
        tick();
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_DEAD;
        mem_auto = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL rmid_first: got %b/%h want 1/00000000", imem_req, imem_addr); end
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b0) begin n_bad++; $display("FAIL rmid_bubble: got %b want 0", IF_ID_Valid); end
        tick();
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'h0 || IF_ID_Instr !== 32'hA5A5_0000) begin
            n_bad++; $display("FAIL rmid_data: got %b/%h/%h want 1/00000000/a5a50000", IF_ID_Valid, IF_ID_PC, IF_ID_Instr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        mem_auto = 1'b1;
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL wrap_noreq: got %b want 0", imem_req); end
        tick();
        branch_taken = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_addr: got %b/%h want 1/fffffffc", imem_req, imem_addr); end
        tick();
        tick();
        #1;
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_pc: got %h want 00000000", imem_addr); end
        tick();
        n_cmp++; if (IF_ID_Valid !== 1'b1 || IF_ID_PC !== 32'hFFFF_FFFC || IF_ID_Instr !== 32'h5A5A_FFFC) begin
            n_bad++; $display("FAIL wrap_ifid: got %b/%h/%h want 1/fffffffc/5a5afffc", IF_ID_Valid, IF_ID_PC, IF_ID_Instr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_branch_wait();
        test_branch_hold();
        test_ready_low();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
